dcache_write_buffer: RTL and testbench

- Victim-line write buffer between the dcache and memory; accepts dirty 256-bit lines evicted by the dcache and queues them in FIFO order.
- Drains queued lines to memory, one line per write transaction.
- Answers dcache lookups so that a line held here is never refetched stale. A lookup read returns the buffered word; a lookup write merges into the buffered line.
- Sits between the dcache and the memory/AXI write port.

---
 rtl/dcache_write_buffer.sv | 253 +++++++++++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   Victim-line write buffer between the dcache and memory. Dirty 256-bit
//   lines evicted by the dcache are queued in FIFO order and drained to
//   memory one line per write transaction. Lookups from the dcache are
//   answered from the buffer so a queued line is never refetched stale:
//   a lookup read returns the buffered word, a lookup write merges into it.
//
//   Optional macro WB_FLUSH_EN adds flush_req / flush_done: while flush_req
//   is high, pushes of new lines are refused, and flush_done reports an
//   empty, idle buffer.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   dcache_write_buffer_en/_physical_addr/_virtual_addr/_data
//                                       line push from the dcache
//   buffer_ready_for_dcache_write       push can be accepted
//   buffer_receive_dcache_write_ok      push accepted this cycle
//   dcache_lookup_en/_write_en/_physical_addr/_write_data
//                                       word lookup (read or merge-write)
//   buffer_hit_success, buffer_hit_data lookup result
//   buffer_write_mem_en/_addr/_data     memory write request
//   mem_receive_buffer_write_ok         memory accepted the request
//   mem_buffer_write_finish             memory write complete
//   buffer_empty                        no valid entries
module dcache_write_buffer #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned LINE_OFFSET_BITS = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dcache_write_buffer_en,
  input  logic [31:0]  dcache_write_buffer_physical_addr,
  input  logic [31:0]  dcache_write_buffer_virtual_addr,
  input  logic [255:0] dcache_write_buffer_data,
  output logic         buffer_ready_for_dcache_write,
  output logic         buffer_receive_dcache_write_ok,
  input  logic         dcache_lookup_en,
  input  logic         dcache_lookup_write_en,
  input  logic [31:0]  dcache_lookup_physical_addr,
  input  logic [31:0]  dcache_lookup_write_data,
  output logic         buffer_hit_success,
  output logic [31:0]  buffer_hit_data,
  output logic         buffer_write_mem_en,
  output logic [31:0]  buffer_write_mem_addr,
  output logic [255:0] buffer_write_mem_data,
  input  logic         mem_receive_buffer_write_ok,
  input  logic         mem_buffer_write_finish,
  output logic         buffer_empty
`ifdef WB_FLUSH_EN
  ,
  input  logic         flush_req,
  output logic         flush_done
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LA_W  = 32 - LINE_OFFSET_BITS;
  localparam int unsigned WD_W  = LINE_OFFSET_BITS - 2;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_SEND,
    WB_WAIT
  } wb_state_t;

  // Entry storage
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] redirty_q;
  logic [LA_W-1:0]  line_q  [DEPTH];
  logic [31:0]      vaddr_q [DEPTH];
  logic [255:0]     data_q  [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  wb_state_t        state_q;
  logic             mem_en_q;

  // Address decode
  logic [LA_W-1:0]  lk_line;
  logic [LA_W-1:0]  ps_line;
  logic [WD_W-1:0]  lk_word;
  logic [WD_W+4:0]  lk_bit;

  assign lk_line = dcache_lookup_physical_addr[31:LINE_OFFSET_BITS];
  assign lk_word = dcache_lookup_physical_addr[LINE_OFFSET_BITS-1:2];
  assign lk_bit  = {lk_word, 5'b0};
  assign ps_line = dcache_write_buffer_physical_addr[31:LINE_OFFSET_BITS];

  // Line matching: lines are held at most once, so at most one entry matches
  logic             lk_match;
  logic [PTR_W-1:0] lk_idx;
  logic             ps_match;
  logic [PTR_W-1:0] ps_idx;

  always_comb begin
    lk_match = 1'b0;
    lk_idx   = '0;
    ps_match = 1'b0;
    ps_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == lk_line)) begin
        lk_match = 1'b1;
        lk_idx   = PTR_W'(i);
      end
      if (valid_q[i] && (line_q[i] == ps_line)) begin
        ps_match = 1'b1;
        ps_idx   = PTR_W'(i);
      end
    end
  end

  // Push handshake
  logic has_room;
  logic accept;
  logic alloc;
  logic [PTR_W-1:0] push_slot;

`ifdef WB_FLUSH_EN
  assign has_room   = (count_q < CNT_W'(DEPTH)) && !flush_req;
  assign flush_done = flush_req && (count_q == '0) && (state_q == WB_IDLE);
`else
  assign has_room   = (count_q < CNT_W'(DEPTH));
`endif

  assign buffer_ready_for_dcache_write  = has_room || ps_match;
  assign accept                         = dcache_write_buffer_en && buffer_ready_for_dcache_write;
  assign buffer_receive_dcache_write_ok = accept;
  assign alloc                          = accept && !ps_match;
  assign push_slot                      = ps_match ? ps_idx : tail_q;

  // Lookup
  logic lk_we;

  assign buffer_hit_success = dcache_lookup_en && lk_match;
  assign buffer_hit_data    = buffer_hit_success ? data_q[lk_idx][lk_bit +: 32] : '0;
  assign lk_we              = buffer_hit_success && dcache_lookup_write_en;

  // Drain bookkeeping. The head counts as in flight once memory has accepted
  // it (including the accepting cycle); a change to it from then on means
  // memory holds stale data and the line must be resent. A change landing in
  // the very cycle the write completes is folded in via head_mod so it
  // triggers the resend instead of being lost by the pop.
  logic head_mod;
  logic in_flight;
  logic mem_done;
  logic resend;
  logic pop;

  assign head_mod  = (accept && ps_match && (ps_idx == head_q)) ||
                     (lk_we && (lk_idx == head_q));
  assign in_flight = (state_q == WB_WAIT) ||
                     ((state_q == WB_SEND) && mem_receive_buffer_write_ok);
  assign mem_done  = ((state_q == WB_WAIT) && mem_buffer_write_finish) ||
                     ((state_q == WB_SEND) && mem_receive_buffer_write_ok &&
                      mem_buffer_write_finish);
  assign resend    = mem_done && (redirty_q[head_q] || head_mod);
  assign pop       = mem_done && !resend;

  // Data path storage; validity is tracked separately, so no reset needed.
  // Lookup word write follows the push write so the lookup word wins.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (accept && (push_slot == PTR_W'(i))) begin
        line_q[i]  <= ps_line;
        vaddr_q[i] <= dcache_write_buffer_virtual_addr;
        data_q[i]  <= dcache_write_buffer_data;
      end
      if (lk_we && (lk_idx == PTR_W'(i))) begin
        data_q[i][lk_bit +: 32] <= dcache_lookup_write_data;
      end
    end
  end

  // Control and drain FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      redirty_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= WB_IDLE;
      mem_en_q  <= 1'b0;
    end else begin
      if (alloc) begin
        valid_q[tail_q]   <= 1'b1;
        redirty_q[tail_q] <= 1'b0;
        tail_q            <= tail_q + 1'b1;
      end

      if (in_flight && head_mod) begin
        redirty_q[head_q] <= 1'b1;
      end

      unique case (state_q)
        WB_IDLE: begin
          if (count_q != '0) begin
            state_q  <= WB_SEND;
            mem_en_q <= 1'b1;
          end
        end
        WB_SEND: begin
          if (mem_receive_buffer_write_ok && !mem_buffer_write_finish) begin
            state_q  <= WB_WAIT;
            mem_en_q <= 1'b0;
          end
        end
        WB_WAIT: ;
        default: begin
          state_q  <= WB_IDLE;
          mem_en_q <= 1'b0;
        end
      endcase

      if (resend) begin
        redirty_q[head_q] <= 1'b0;
        state_q           <= WB_SEND;
        mem_en_q          <= 1'b1;
      end

      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        state_q         <= WB_IDLE;
        mem_en_q        <= 1'b0;
      end

      unique case ({alloc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign buffer_write_mem_en   = mem_en_q;
  assign buffer_write_mem_addr = mem_en_q ? {line_q[head_q], {LINE_OFFSET_BITS{1'b0}}} : '0;
  assign buffer_write_mem_data = mem_en_q ? data_q[head_q] : '0;
  assign buffer_empty          = (count_q == '0);

  // Virtual address is retained with the entry but never matched on
  logic unused_bits;
  always_comb begin
    unused_bits = ^{dcache_lookup_physical_addr[1:0],
                    dcache_write_buffer_physical_addr[LINE_OFFSET_BITS-1:0]};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_bits = unused_bits ^ (^vaddr_q[i]);
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Testbench for dcache_write_buffer: cycle-by-cycle vector table plus
// hand-written sequences for the resend-after-merge path and (with
// WB_FLUSH_EN) the flush handshake.
module tb_dcache_write_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         push_en;
  logic [31:0]  push_paddr;
  logic [31:0]  push_vaddr;
  logic [255:0] push_data;
  logic         rdy;
  logic         rok;
  logic         lk_en;
  logic         lk_we;
  logic [31:0]  lk_addr;
  logic [31:0]  lk_wdata;
  logic         hit;
  logic [31:0]  hit_data;
  logic         mem_en;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data;
  logic         mem_ok;
  logic         mem_fin;
  logic         empty;
`ifdef WB_FLUSH_EN
  logic         flush_req;
  logic         flush_done;
`endif

  dcache_write_buffer #(.DEPTH(4), .LINE_OFFSET_BITS(5)) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .dcache_write_buffer_en            (push_en),
    .dcache_write_buffer_physical_addr (push_paddr),
    .dcache_write_buffer_virtual_addr  (push_vaddr),
    .dcache_write_buffer_data          (push_data),
    .buffer_ready_for_dcache_write     (rdy),
    .buffer_receive_dcache_write_ok    (rok),
    .dcache_lookup_en                  (lk_en),
    .dcache_lookup_write_en            (lk_we),
    .dcache_lookup_physical_addr       (lk_addr),
    .dcache_lookup_write_data          (lk_wdata),
    .buffer_hit_success                (hit),
    .buffer_hit_data                   (hit_data),
    .buffer_write_mem_en               (mem_en),
    .buffer_write_mem_addr             (mem_addr),
    .buffer_write_mem_data             (mem_data),
    .mem_receive_buffer_write_ok       (mem_ok),
    .mem_buffer_write_finish           (mem_fin),
    .buffer_empty                      (empty)
`ifdef WB_FLUSH_EN
    ,
    .flush_req                         (flush_req),
    .flush_done                        (flush_done)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        pe;
    logic [31:0] pa;
    logic [31:0] ps;
    logic        le;
    logic        lw;
    logic [31:0] la;
    logic [31:0] ld;
    logic        ok;
    logic        fin;
    logic        e_rdy;
    logic        e_rok;
    logic        e_hit;
    logic [31:0] e_hd;
    logic        e_men;
    logic [31:0] e_ma;
    logic [31:0] e_w0;
    logic [31:0] e_w3;
    logic        e_emp;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  localparam logic [31:0] L0 = 32'h1000_0040;
  localparam logic [31:0] L1 = 32'h3000_0000;
  localparam logic [31:0] L2 = 32'h3000_0020;
  localparam logic [31:0] L3 = 32'h3000_0040;
  localparam logic [31:0] L4 = 32'h3000_0060;
  localparam logic [31:0] L5 = 32'h3000_0080;
  localparam logic [31:0] L6 = 32'h3000_00A0;
  localparam logic [31:0] L7 = 32'h3000_00C0;

  function automatic logic [255:0] mk_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = seed + 32'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic pe, input logic [31:0] pa, input logic [31:0] ps,
                       input logic le, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld, input logic ok, input logic fin);
    push_en    = pe;
    push_paddr = pe ? pa : 32'h0;
    push_vaddr = pe ? (pa ^ 32'h8000_0000) : 32'h0;
    push_data  = pe ? mk_line(ps) : '0;
    lk_en      = le;
    lk_we      = lw;
    lk_addr    = la;
    lk_wdata   = ld;
    mem_ok     = ok;
    mem_fin    = fin;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Caller is mid-cycle with idle inputs; waits a bounded number of cycles
  task automatic wait_send(input string nm);
    int n = 0;
    while (mem_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(nm, {31'b0, mem_en}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          pe pa  ps      le lw la            ld ok fin  rdy rok hit hd      men ma  w0      w3      emp
    vecs[0]  = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      1};
    vecs[1]  = '{1, L0, 0,      0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      0,  0,  0,      0,      1};
    vecs[2]  = '{0, 0,  0,      1, 0, 32'h10000048, 0, 0, 0,   1,  0,  1,  2,      0,  0,  0,      0,      0};
    vecs[3]  = '{0, 0,  0,      0, 0, 0,            0, 1, 0,   1,  0,  0,  0,      1,  L0, 0,      3,      0};
    vecs[4]  = '{0, 0,  0,      0, 0, 0,            0, 0, 1,   1,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[5]  = '{0, 0,  0,      1, 0, 32'h10000048, 0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      1};
    vecs[6]  = '{1, L1, 'h100,  0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      0,  0,  0,      0,      1};
    vecs[7]  = '{1, L2, 'h200,  0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      0,  0,  0,      0,      0};
    vecs[8]  = '{1, L3, 'h300,  0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      1,  L1, 'h100,  'h103,  0};
    vecs[9]  = '{1, L4, 'h400,  0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      1,  L1, 'h100,  'h103,  0};
    vecs[10] = '{1, L5, 'h500,  1, 0, 32'h20000000, 0, 0, 0,   0,  0,  0,  0,      1,  L1, 'h100,  'h103,  0};
    vecs[11] = '{1, L2, 'h250,  1, 0, 32'h30000048, 0, 0, 0,   1,  1,  1,  'h302,  1,  L1, 'h100,  'h103,  0};
    vecs[12] = '{1, L5, 'h500,  0, 0, 0,            0, 0, 0,   0,  0,  0,  0,      1,  L1, 'h100,  'h103,  0};
    vecs[13] = '{0, 0,  0,      1, 0, 32'h30000024, 0, 0, 0,   0,  0,  1,  'h251,  1,  L1, 'h100,  'h103,  0};
    vecs[14] = '{0, 0,  0,      0, 0, 0,            0, 1, 0,   0,  0,  0,  0,      1,  L1, 'h100,  'h103,  0};
    vecs[15] = '{1, L5, 'h500,  0, 0, 0,            0, 0, 1,   0,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[16] = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[17] = '{0, 0,  0,      0, 0, 0,            0, 1, 0,   1,  0,  0,  0,      1,  L2, 'h250,  'h253,  0};
    vecs[18] = '{1, L5, 'h500,  0, 0, 0,            0, 0, 1,   1,  1,  0,  0,      0,  0,  0,      0,      0};
    vecs[19] = '{1, L6, 'h600,  0, 0, 0,            0, 0, 0,   1,  1,  0,  0,      0,  0,  0,      0,      0};
    vecs[20] = '{1, L7, 'h700,  0, 0, 0,            0, 1, 1,   0,  0,  0,  0,      1,  L3, 'h300,  'h303,  0};
    vecs[21] = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[22] = '{0, 0,  0,      0, 0, 0,            0, 1, 1,   1,  0,  0,  0,      1,  L4, 'h400,  'h403,  0};
    vecs[23] = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[24] = '{0, 0,  0,      0, 0, 0,            0, 1, 1,   1,  0,  0,  0,      1,  L5, 'h500,  'h503,  0};
    vecs[25] = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      0};
    vecs[26] = '{0, 0,  0,      0, 0, 0,            0, 1, 1,   1,  0,  0,  0,      1,  L6, 'h600,  'h603,  0};
    vecs[27] = '{0, 0,  0,      0, 0, 0,            0, 0, 0,   1,  0,  0,  0,      0,  0,  0,      0,      1};

    rst_n = 1'b0;
    idle();
`ifdef WB_FLUSH_EN
    flush_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k].pe, vecs[k].pa, vecs[k].ps, vecs[k].le, vecs[k].lw,
            vecs[k].la, vecs[k].ld, vecs[k].ok, vecs[k].fin);
      #2;
      chk($sformatf("v%0d.ready", k), {31'b0, rdy},   {31'b0, vecs[k].e_rdy});
      chk($sformatf("v%0d.recv",  k), {31'b0, rok},   {31'b0, vecs[k].e_rok});
      chk($sformatf("v%0d.hit",   k), {31'b0, hit},   {31'b0, vecs[k].e_hit});
      chk($sformatf("v%0d.hdata", k), hit_data,       vecs[k].e_hd);
      chk($sformatf("v%0d.memen", k), {31'b0, mem_en}, {31'b0, vecs[k].e_men});
      chk($sformatf("v%0d.maddr", k), mem_addr,       vecs[k].e_ma);
      chk($sformatf("v%0d.mw0",   k), mem_data[31:0], vecs[k].e_w0);
      chk($sformatf("v%0d.mw3",   k), mem_data[127:96], vecs[k].e_w3);
      chk($sformatf("v%0d.empty", k), {31'b0, empty}, {31'b0, vecs[k].e_emp});
    end

    // Lookup write into the in-flight head, then resend of the merged line
    @(negedge clk);
    drive(1'b1, 32'h4000_0000, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("c.push_ok", {31'b0, rok}, 32'd1);
    @(negedge clk);
    idle();
    #2;
    wait_send("c.send1");
    chk("c.addr1", mem_addr, 32'h4000_0000);
    chk("c.w3_1", mem_data[127:96], 32'h803);
    mem_ok = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000_000C, 32'hDEAD_BEEF, 1'b0, 1'b0);
    #2;
    chk("c.wait_memen", {31'b0, mem_en}, 32'd0);
    chk("c.lkw_hit", {31'b0, hit}, 32'd1);
    chk("c.lkw_old", hit_data, 32'h803);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #2;
    chk("c.fin_empty", {31'b0, empty}, 32'd0);
    @(negedge clk);
    idle();
    #2;
    chk("c.resend_en", {31'b0, mem_en}, 32'd1);
    chk("c.resend_addr", mem_addr, 32'h4000_0000);
    chk("c.resend_w0", mem_data[31:0], 32'h800);
    chk("c.resend_w3", mem_data[127:96], 32'hDEAD_BEEF);
    mem_ok  = 1'b1;
    mem_fin = 1'b1;
    @(negedge clk);
    idle();
    #2;
    chk("c.popped_empty", {31'b0, empty}, 32'd1);
    chk("c.popped_memen", {31'b0, mem_en}, 32'd0);

`ifdef WB_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h5000_0000 + 32'(k) * 32'h20, 32'h900 + 32'(k) * 32'h100,
            1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      chk($sformatf("f.push%0d", k), {31'b0, rok}, 32'd1);
    end
    @(negedge clk);
    idle();
    flush_req = 1'b1;
    #2;
    chk("f.done_busy", {31'b0, flush_done}, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h5000_0060, 32'hC00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("f.new_ready", {31'b0, rdy}, 32'd0);
    chk("f.new_recv", {31'b0, rok}, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h5000_0000, 32'h950, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("f.hit_recv", {31'b0, rok}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      #2;
      wait_send($sformatf("f.send%0d", k));
      chk($sformatf("f.addr%0d", k), mem_addr, 32'h5000_0000 + 32'(k) * 32'h20);
      chk($sformatf("f.w0_%0d", k), mem_data[31:0], (k == 0) ? 32'h950 : 32'h900 + 32'(k) * 32'h100);
      chk($sformatf("f.done_s%0d", k), {31'b0, flush_done}, 32'd0);
      mem_ok = 1'b1;
      @(negedge clk);
      idle();
      mem_fin = 1'b1;
      #2;
      chk($sformatf("f.done_w%0d", k), {31'b0, flush_done}, 32'd0);
    end
    @(negedge clk);
    idle();
    #2;
    chk("f.done", {31'b0, flush_done}, 32'd1);
    chk("f.empty", {31'b0, empty}, 32'd1);
    @(negedge clk);
    flush_req = 1'b0;
    #2;
    chk("f.done_drop", {31'b0, flush_done}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
